// File: rtl/urisc_pkg.sv
// Shared types for the URISC SUBLEQ sequencer.
// Optional halt support is selected with SUBLEQ_HALT_EN.
package urisc_pkg;

  localparam int WORD_SIZE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_AB,
    FETCH_C,
    READ_OPS,
    EXEC,
    HALT
  } state_t;

endpackage

// File: rtl/subleq_sequencer_if.sv
// Dual-port word memory bundle driven by the SUBLEQ sequencer.
// The sequencer holds the master modport; the memory holds the slave modport.
interface subleq_sequencer_if #(
  parameter int W = 16
);

  logic [W-1:0] mem_add1;
  logic [W-1:0] mem_din1;
  logic         mem_we1;
  logic [W-1:0] mem_dout1;
  logic [W-1:0] mem_add2;
  logic [W-1:0] mem_din2;
  logic         mem_we2;
  logic [W-1:0] mem_dout2;

  modport master (
    output mem_add1,
    output mem_din1,
    output mem_we1,
    input  mem_dout1,
    output mem_add2,
    output mem_din2,
    output mem_we2,
    input  mem_dout2
  );

  modport slave (
    input  mem_add1,
    input  mem_din1,
    input  mem_we1,
    output mem_dout1,
    input  mem_add2,
    input  mem_din2,
    input  mem_we2,
    output mem_dout2
  );

endinterface

// File: rtl/subleq_sequencer_alu.sv
// SUBLEQ arithmetic: diff = b - a, leq when diff is signed <= 0.
// Purely combinational.
module subleq_alu #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         leq
);

  assign diff = b - a;
  assign leq  = diff[W-1] | (diff == '0);

endmodule

// File: rtl/subleq_sequencer.sv
// SUBLEQ instruction sequencer, four cycles per instruction.
// Define SUBLEQ_HALT_EN to stop on a taken self-loop branch.
module subleq_sequencer
  import urisc_pkg::*;
#(
  parameter int                   WORD_SIZE = WORD_SIZE_DEF,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  subleq_sequencer_if.master   mem,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 retired,
  output logic                 halted
);

  localparam int W = WORD_SIZE;

  state_t       state;
  logic [W-1:0] c;
  logic [W-1:0] add1;
  logic [W-1:0] add2;
  logic         we2;
  logic [W-1:0] diff;
  logic         leq;
  logic [W-1:0] next_pc;
  logic         self_loop;

  subleq_alu #(.W(W)) u_alu (
    .a    (mem.mem_dout1),
    .b    (mem.mem_dout2),
    .diff (diff),
    .leq  (leq)
  );

  assign next_pc   = leq ? c : pc + W'(3);
  assign self_loop = leq && (c == pc);

  // Write data is only meaningful while we2 is up (the EXEC cycle)
  assign mem.mem_add1 = add1;
  assign mem.mem_din1 = '0;
  assign mem.mem_we1  = 1'b0;
  assign mem.mem_add2 = add2;
  assign mem.mem_din2 = we2 ? diff : '0;
  assign mem.mem_we2  = we2;

`ifndef SUBLEQ_HALT_EN
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      c       <= '0;
      add1    <= '0;
      add2    <= '0;
      we2     <= 1'b0;
      retired <= 1'b0;
`ifdef SUBLEQ_HALT_EN
      halted  <= 1'b0;
`endif
    end else begin
      we2     <= 1'b0;
      retired <= 1'b0;
      unique case (state)
        IDLE: begin
          if (run) begin
            state <= FETCH_AB;
            add1  <= pc;
            add2  <= pc + W'(1);
          end
        end
        FETCH_AB: begin
          state <= FETCH_C;
          add1  <= pc + W'(2);
          add2  <= '0;
        end
        FETCH_C: begin
          state <= READ_OPS;
          add1  <= mem.mem_dout1;
          add2  <= mem.mem_dout2;
        end
        READ_OPS: begin
          state   <= EXEC;
          c       <= mem.mem_dout1;
          add1    <= '0;
          we2     <= 1'b1;
          retired <= 1'b1;
        end
        EXEC: begin
          pc <= next_pc;
`ifdef SUBLEQ_HALT_EN
          if (self_loop) begin
            state  <= HALT;
            halted <= 1'b1;
            add1   <= '0;
            add2   <= '0;
          end else
`endif
          if (run) begin
            state <= FETCH_AB;
            add1  <= next_pc;
            add2  <= next_pc + W'(1);
          end else begin
            state <= IDLE;
            add1  <= '0;
            add2  <= '0;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  logic unused;
  assign unused = self_loop;

endmodule

// File: tb/tb_subleq_sequencer.sv
// Directed bench for subleq_sequencer with two dual-port memories.
// Instance u1 starts at 0xFFFE to cover address wrap.
module tb_subleq_sequencer;
  import urisc_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst0_n, rst1_n;
  logic         run0, run1;
  logic [W-1:0] pc0, pc1;
  logic         ret0, ret1;
  logic         hlt0, hlt1;

  subleq_sequencer_if #(.W(W)) m0 ();
  subleq_sequencer_if #(.W(W)) m1 ();

  subleq_sequencer #(
    .WORD_SIZE (W),
    .RESET_PC  (16'h0000)
  ) u0 (
    .clk     (clk),
    .rst_n   (rst0_n),
    .run     (run0),
    .mem     (m0),
    .pc      (pc0),
    .retired (ret0),
    .halted  (hlt0)
  );

  subleq_sequencer #(
    .WORD_SIZE (W),
    .RESET_PC  (16'hFFFE)
  ) u1 (
    .clk     (clk),
    .rst_n   (rst1_n),
    .run     (run1),
    .mem     (m1),
    .pc      (pc1),
    .retired (ret1),
    .halted  (hlt1)
  );

  logic [W-1:0] ram0 [0:65535];
  logic [W-1:0] ram1 [0:65535];
  logic         ld0, ld1;
  logic [W-1:0] ld_addr, ld_data;

  always @(posedge clk) begin
    if (m0.mem_we2) ram0[m0.mem_add2] <= m0.mem_din2;
    if (m0.mem_we1) ram0[m0.mem_add1] <= m0.mem_din1;
    if (ld0) ram0[ld_addr] <= ld_data;
    if (!m0.mem_we1) m0.mem_dout1 <= ram0[m0.mem_add1];
    if (!m0.mem_we2) m0.mem_dout2 <= ram0[m0.mem_add2];
  end

  always @(posedge clk) begin
    if (m1.mem_we2) ram1[m1.mem_add2] <= m1.mem_din2;
    if (m1.mem_we1) ram1[m1.mem_add1] <= m1.mem_din1;
    if (ld1) ram1[ld_addr] <= ld_data;
    if (!m1.mem_we1) m1.mem_dout1 <= ram1[m1.mem_add1];
    if (!m1.mem_we2) m1.mem_dout2 <= ram1[m1.mem_add2];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input bit sel,
                      input logic [W-1:0] a,
                      input logic [W-1:0] d);
    ld_addr = a;
    ld_data = d;
    if (sel) ld1 = 1'b1;
    else ld0 = 1'b1;
    @(negedge clk);
    ld0 = 1'b0;
    ld1 = 1'b0;
  endtask

  int cnt;
  int busy;

  initial begin
    rst0_n  = 1'b0;
    rst1_n  = 1'b0;
    run0    = 1'b0;
    run1    = 1'b0;
    ld0     = 1'b0;
    ld1     = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    @(negedge clk);

    chk("rst_pc0", pc0, 16'h0000);
    chk("rst_pc1", pc1, 16'hFFFE);
    chk("rst_we1", m0.mem_we1, 1'b0);
    chk("rst_we2", m0.mem_we2, 1'b0);
    chk("rst_add1", m0.mem_add1, 16'h0);
    chk("rst_din2", m0.mem_din2, 16'h0);
    chk("rst_ret", ret0, 1'b0);
    chk("rst_hlt", hlt0, 1'b0);

    load(0, 16'd0, 16'd10);
    load(0, 16'd1, 16'd11);
    load(0, 16'd2, 16'd6);
    load(0, 16'd10, 16'd3);
    load(0, 16'd11, 16'd5);
    load(0, 16'd3, 16'd10);
    load(0, 16'd4, 16'd11);
    load(0, 16'd5, 16'd6);
    load(0, 16'd6, 16'd12);
    load(0, 16'd7, 16'd12);
    load(0, 16'd8, 16'd20);
    load(0, 16'd12, 16'h1234);
    load(0, 16'd20, 16'd15);
    load(0, 16'd21, 16'd16);
    load(0, 16'd22, 16'd9);
    load(0, 16'd15, 16'd1);
    load(0, 16'd16, 16'd1);
    load(1, 16'hFFFE, 16'd30);
    load(1, 16'hFFFF, 16'd31);
    load(1, 16'h0000, 16'd100);
    load(1, 16'd30, 16'd1);
    load(1, 16'd31, 16'd4);

    rst0_n = 1'b1;
    rst1_n = 1'b1;
    tick(3);
    chk("idle_pc", pc0, 16'h0);
    chk("idle_we2", m0.mem_we2, 1'b0);
    chk("idle_add1", m0.mem_add1, 16'h0);
    chk("idle_ret", ret0, 1'b0);

    // No branch: 5 - 3 = 2
    run0 = 1'b1;
    tick();
    chk("fab_add1", m0.mem_add1, 16'd0);
    chk("fab_add2", m0.mem_add2, 16'd1);
    tick();
    chk("fc_add1", m0.mem_add1, 16'd2);
    tick();
    chk("rop_add1", m0.mem_add1, 16'd10);
    chk("rop_add2", m0.mem_add2, 16'd11);
    tick();
    chk("ex_ret", ret0, 1'b1);
    chk("ex_we2", m0.mem_we2, 1'b1);
    chk("ex_add2", m0.mem_add2, 16'd11);
    chk("ex_din2", m0.mem_din2, 16'd2);
    chk("ex_pc", pc0, 16'd0);
    run0 = 1'b0;
    tick();
    chk("nb_pc", pc0, 16'd3);
    chk("nb_mem", ram0[11], 16'd2);
    chk("nb_ret", ret0, 1'b0);
    chk("nb_we2", m0.mem_we2, 1'b0);
    tick(2);
    chk("nb_idle", m0.mem_add1, 16'd0);
    chk("nb_pc2", pc0, 16'd3);

    // Branch: 5 - 7 = -2, run dropped in FETCH_C
    load(0, 16'd10, 16'd7);
    load(0, 16'd11, 16'd5);
    run0 = 1'b1;
    tick(2);
    run0 = 1'b0;
    tick(2);
    chk("br_ret", ret0, 1'b1);
    chk("br_din2", m0.mem_din2, 16'hFFFE);
    tick();
    chk("br_pc", pc0, 16'd6);
    chk("br_mem", ram0[11], 16'hFFFE);
    tick(3);
    chk("br_idle_ret", ret0, 1'b0);
    chk("br_idle_pc", pc0, 16'd6);
    chk("br_idle_we", m0.mem_we2, 1'b0);
    chk("br_idle_add", m0.mem_add1, 16'd0);

    load(0, 16'd9, 16'd12);
    load(0, 16'd10, 16'd12);
    load(0, 16'd11, 16'd9);

    // A==B at pc 6, then pc 20, then self-loop at 9
    run0 = 1'b1;
    tick(4);
    chk("ab_add2", m0.mem_add2, 16'd12);
    chk("ab_din2", m0.mem_din2, 16'd0);
    tick();
    chk("ab_pc", pc0, 16'd20);
    chk("ab_mem", ram0[12], 16'd0);
    tick(3);
    chk("i20_add2", m0.mem_add2, 16'd16);
    chk("i20_din2", m0.mem_din2, 16'd0);
    tick();
    chk("i20_pc", pc0, 16'd9);
    chk("i20_mem", ram0[16], 16'd0);
    tick(3);
    chk("i9_ret", ret0, 1'b1);
    chk("i9_we2", m0.mem_we2, 1'b1);
    chk("i9_add2", m0.mem_add2, 16'd12);

`ifdef SUBLEQ_HALT_EN
    tick();
    chk("h_hlt", hlt0, 1'b1);
    chk("h_pc", pc0, 16'd9);
    busy = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ret0 || m0.mem_we2 || m0.mem_add1 != 0
          || m0.mem_add2 != 0)
        busy++;
    end
    chk("h_quiet", busy, 0);
    run0 = 1'b0;
    tick(2);
    chk("h_sticky", hlt0, 1'b1);
    chk("h_pc2", pc0, 16'd9);
`else
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ret0) cnt++;
    end
    chk("loop_cnt", cnt, 4);
    chk("loop_pc", pc0, 16'd9);
    chk("loop_hlt", hlt0, 1'b0);
    run0 = 1'b0;
    tick(4);
    chk("loop_idle", m0.mem_add1, 16'd0);
    chk("loop_pc2", pc0, 16'd9);
`endif

    // Wrap: 4 - 1 = 3, pc 0xFFFE + 3 = 0x0001
    run1 = 1'b1;
    tick();
    chk("w_add1", m1.mem_add1, 16'hFFFE);
    chk("w_add2", m1.mem_add2, 16'hFFFF);
    tick();
    chk("w_fc_add1", m1.mem_add1, 16'h0000);
    tick();
    chk("w_rop_add1", m1.mem_add1, 16'd30);
    chk("w_rop_add2", m1.mem_add2, 16'd31);
    tick();
    chk("w_din2", m1.mem_din2, 16'd3);
    run1 = 1'b0;
    tick();
    chk("w_pc", pc1, 16'h0001);
    chk("w_mem", ram1[31], 16'd3);

    // Abort in EXEC via async reset
    rst1_n = 1'b0;
    tick();
    chk("ab_rst_pc", pc1, 16'hFFFE);
    rst1_n = 1'b1;
    run1 = 1'b1;
    tick(4);
    chk("abt_we_pre", m1.mem_we2, 1'b1);
    rst1_n = 1'b0;
    #1;
    chk("abt_we", m1.mem_we2, 1'b0);
    tick();
    chk("abt_mem", ram1[31], 16'd3);
    chk("abt_pc", pc1, 16'hFFFE);
    run1 = 1'b0;
    rst1_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
